// File: rtl/ahb_mem.sv
// Byte-lane-writable storage array behind the AHB3-Lite slave.
// Synchronous per-lane write, combinational read at the same address.
module ahb_mem #(
  parameter int ABITS = 8,
  parameter int DBITS = 32
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [ABITS-1:0]   addr_i,
  input  logic               we_i,
  input  logic [(DBITS+7)/8-1:0] be_i,
  input  logic [DBITS-1:0]   din_i,
  output logic [DBITS-1:0]   dout_o
);

  localparam int BE    = (DBITS + 7) / 8;
  localparam int DEPTH = 2 ** ABITS;

  logic [DBITS-1:0] mem [DEPTH];
  logic [DBITS-1:0] wmask;

  // Expand lane enables to a bit mask; a partial top lane just gets fewer bits.
  for (genvar b = 0; b < DBITS; b++) begin : g_mask
    assign wmask[b] = be_i[b / 8];
  end

  // Writes are gated by the reset level; contents survive reset untouched.
  always_ff @(posedge HCLK) begin
    if (HRESETn && we_i) begin
      mem[addr_i] <= (mem[addr_i] & ~wmask) | (din_i & wmask);
    end
  end

  // No bypass: read-during-write shows the old word until the edge.
  assign dout_o = mem[addr_i];

endmodule

// File: tb/tb_ahb_mem.sv
// Self-checking bench for ahb_mem: byte-array reference model, expected queue
// filled by the driver and drained by a negedge monitor.
module tb_ahb_mem;

  localparam int ABITS = 8;
  localparam int DBITS = 32;
  localparam int BE    = 4;

  logic              HCLK;
  logic              HRESETn;
  logic [ABITS-1:0]  addr_i;
  logic              we_i;
  logic [BE-1:0]     be_i;
  logic [DBITS-1:0]  din_i;
  logic [DBITS-1:0]  dout_o;

  ahb_mem #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .addr_i  (addr_i),
    .we_i    (we_i),
    .be_i    (be_i),
    .din_i   (din_i),
    .dout_o  (dout_o)
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // reference model: the array as individual bytes
  logic [7:0] mb [256][BE];

  logic [DBITS-1:0] exp_q[$];
  string            name_q[$];
  logic             rd_valid;
  int               checks;
  int               errors;

  function automatic logic [DBITS-1:0] model_word(input logic [ABITS-1:0] a);
    logic [DBITS-1:0] w;
    for (int n = 0; n < BE; n++) w[8*n +: 8] = mb[a][n];
    return w;
  endfunction

  // One bus cycle: inputs change 2ns after the rising edge, held through the next edge.
  // When chk is set the current (pre-edge) read value is expected at the negedge.
  task automatic cyc(input logic rst, input logic we, input logic [ABITS-1:0] a,
                     input logic [BE-1:0] be, input logic [DBITS-1:0] d,
                     input bit chk, input string nm);
    @(posedge HCLK);
    #2;
    HRESETn  = rst;
    we_i     = we;
    addr_i   = a;
    be_i     = be;
    din_i    = d;
    rd_valid = chk;
    if (chk) begin
      exp_q.push_back(model_word(a));
      name_q.push_back(nm);
    end
    if (we && rst) begin
      for (int n = 0; n < BE; n++)
        if (be[n]) mb[a][n] = d[8*n +: 8];
    end
  endtask

  task automatic wr(input logic [ABITS-1:0] a, input logic [BE-1:0] be, input logic [DBITS-1:0] d);
    cyc(1'b1, 1'b1, a, be, d, 1'b0, "");
  endtask

  task automatic rd(input logic [ABITS-1:0] a, input string nm);
    cyc(1'b1, 1'b0, a, '0, '0, 1'b1, nm);
  endtask

  // checks a model value against a hand-derived constant, so the model itself is pinned
  task automatic pin(input logic [ABITS-1:0] a, input logic [DBITS-1:0] want, input string nm);
    checks++;
    if (model_word(a) !== want) begin
      errors++;
      $display("FAIL %s: model holds %08h, required %08h", nm, model_word(a), want);
    end
  endtask

  // scoreboard monitor
  always @(negedge HCLK) begin
    if (rd_valid) begin
      logic [DBITS-1:0] e;
      string nm;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: read with no expected value, got %08h", dout_o);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (dout_o !== e) begin
          errors++;
          $display("FAIL %s: dout_o=%08h expected %08h", nm, dout_o, e);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rd_valid = 1'b0;
    HRESETn  = 1'b0;
    we_i     = 1'b0;
    addr_i   = '0;
    be_i     = '0;
    din_i    = '0;
    repeat (3) @(posedge HCLK);

    // preload every word so later reads never see X
    for (int a = 0; a < 256; a++) begin
      logic [DBITS-1:0] v;
      v = $urandom;
      if (a == 'h10) v = 32'h0;
      if (a == 'h20) v = 32'h0123_4567;
      wr(a[ABITS-1:0], 4'hF, v);
    end

    // full write / read
    wr(8'h05, 4'hF, 32'hDEAD_BEEF);
    rd(8'h05, "full_rw");
    pin(8'h05, 32'hDEAD_BEEF, "full_rw_const");

    // partial lanes
    wr(8'h05, 4'b0010, 32'h0000_AA00);
    rd(8'h05, "lane1");
    pin(8'h05, 32'hDEAD_AAEF, "lane1_const");
    wr(8'h05, 4'b1000, 32'h1100_0000);
    rd(8'h05, "lane3");
    pin(8'h05, 32'h11AD_AAEF, "lane3_const");

    // read-during-write: old word before the edge, new word after
    cyc(1'b1, 1'b1, 8'h10, 4'hF, 32'h1234_5678, 1'b1, "rdw_old");
    rd(8'h10, "rdw_new");
    pin(8'h10, 32'h1234_5678, "rdw_const");

    // accumulating lanes on consecutive edges
    wr(8'h30, 4'b0011, 32'hCAFE_F00D);
    wr(8'h30, 4'b1100, 32'hBEEF_0000);
    rd(8'h30, "accum");

    // boundary addresses
    wr(8'h00, 4'hF, 32'hA5A5_A5A5);
    wr(8'hFF, 4'hF, 32'h5A5A_5A5A);
    rd(8'h00, "iso_lo");
    rd(8'hFF, "iso_hi");
    pin(8'h00, 32'hA5A5_A5A5, "iso_lo_const");

    // reset gating
    cyc(1'b0, 1'b1, 8'h20, 4'hF, 32'hFFFF_FFFF, 1'b0, "");
    cyc(1'b0, 1'b1, 8'h20, 4'hF, 32'hFFFF_FFFF, 1'b0, "");
    rd(8'h20, "rst_gate");
    pin(8'h20, 32'h0123_4567, "rst_gate_const");
    wr(8'h20, 4'hF, 32'hFFFF_FFFF);
    rd(8'h20, "rst_release");

    // be=0 no-op
    wr(8'h05, 4'h0, 32'hFFFF_FFFF);
    rd(8'h05, "be_zero");

    // randomized traffic, mixing writes and reset pulses, reading every cycle
    for (int i = 0; i < 400; i++) begin
      logic [ABITS-1:0] a;
      case ($urandom_range(0, 3))
        0:       a = 8'h00;
        1:       a = 8'hFF;
        default: a = $urandom_range(0, 15);
      endcase
      cyc(($urandom_range(0, 15) != 0), $urandom_range(0, 1), a,
          $urandom_range(0, 15), $urandom, 1'b1, "rand");
    end

    cyc(1'b1, 1'b0, 8'h00, 4'h0, '0, 1'b0, "");
    @(posedge HCLK);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected values never compared, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
